// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants for the memory-mapped 7-segment scan display.
package seg_disp_pkg;
    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG7_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_HOLD     = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int REG_DATA_OFS  = 0;
    localparam int REG_CTRL_OFS  = 4;
endpackage

// File: rtl/seg7_nibble_decode.sv
// seg7_nibble_decode: combinational hex nibble to active-low 7-segment pattern.
module seg7_nibble_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG7_CODE[nibble];
endmodule

// File: rtl/mmio_seg_scan_display.sv
// mmio_seg_scan_display: bus-mapped DATA/CTRL registers driving a scanned common-anode hex display.
// Define SEG_LEAD_ZERO_BLANK_EN to auto-blank leading zero digits (digit 0 is always shown).
module mmio_seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_DIGITS = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0064,
    parameter int                SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wen,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [DATA_W-1:0]     disp_q
);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    if (NUM_DIGITS > DATA_W / 4) begin : g_bad_digits
        $error("NUM_DIGITS must not exceed DATA_W/4");
    end
    if (NUM_DIGITS + CTRL_MASK_LSB > DATA_W) begin : g_bad_mask
        $error("blank mask does not fit in CTRL");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV must be at least 2");
    end

    logic [DATA_W-1:0]     data_q, bmask;
    logic                  en_q, hold_q;
    logic [NUM_DIGITS-1:0] mask_q, mask_d, an_d;
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            nibble;
    logic [6:0]            dec, seg_d;
    logic                  hit_data, hit_ctrl, run, presc_wrap, lead_blank, blank;

    assign hit_data = wen && addr == BASE_ADDR + ADDR_W'(REG_DATA_OFS);
    assign hit_ctrl = wen && addr == BASE_ADDR + ADDR_W'(REG_CTRL_OFS);

    always_comb begin
        bmask  = '0;
        mask_d = mask_q;
        for (int i = 0; i < DATA_W / 8; i++) bmask[8*i +: 8] = {8{wstrb[i]}};
        for (int i = 0; i < NUM_DIGITS; i++)
            mask_d[i] = wstrb[(CTRL_MASK_LSB + i) / 8] ? wdata[CTRL_MASK_LSB + i] : mask_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            en_q   <= 1'b1;
            hold_q <= 1'b0;
            mask_q <= '0;
        end else begin
            if (hit_data) data_q <= (data_q & ~bmask) | (wdata & bmask);
            if (hit_ctrl) begin
                en_q   <= wstrb[CTRL_EN / 8] ? wdata[CTRL_EN] : en_q;
                hold_q <= wstrb[CTRL_HOLD / 8] ? wdata[CTRL_HOLD] : hold_q;
                mask_q <= mask_d;
            end
        end
    end

    // Counters freeze in place while disabled or held so scanning resumes where it stopped
    assign run        = en_q && !hold_q;
    assign presc_wrap = presc == PRE_W'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (run) begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap) idx <= idx == IDX_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] nz_above;
    logic                  acc;
    always_comb begin
        acc      = 1'b0;
        nz_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc         = acc | (|data_q[4*i +: 4]);
            nz_above[i] = acc;
        end
    end
    assign lead_blank = idx != '0 && !nz_above[idx];
`else
    assign lead_blank = 1'b0;
`endif

    assign nibble = data_q[{idx, 2'b00} +: 4];

    seg7_nibble_decode u_dec (
        .nibble(nibble),
        .seg   (dec)
    );

    assign blank = !en_q || mask_q[idx] || lead_blank;
    assign an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx);
    assign seg_d = blank ? SEG_BLANK : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

    assign disp_q = data_q;
endmodule

// File: tb/tb_mmio_seg_scan_display.sv
// tb_mmio_seg_scan_display: directed self-checking bench, 8 digits, 4 clocks per digit slot.
module tb_mmio_seg_scan_display;
    localparam logic [31:0] BASE = 32'h8000_0064;

    logic        clk = 1'b0, rst_n = 1'b0, wen = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] disp_q;
    int checks = 0, errors = 0;

    mmio_seg_scan_display #(
        .ADDR_W(32), .DATA_W(32), .NUM_DIGITS(8), .BASE_ADDR(BASE), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .wen(wen), .seg(seg), .an(an), .disp_q(disp_q)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the store is captured on the next posedge and the task returns one negedge later
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic v);
        addr = a; wdata = d; wstrb = s; wen = v;
        @(negedge clk);
        wen = 1'b0; wstrb = '0;
    endtask

    task automatic wait_an(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || disp_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h disp_q=%h, want an=ff seg=7f disp_q=0", an, seg, disp_q);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_an = ~(8'd1 << (k / 4));
            checks++;
            if (an !== exp_an || seg !== 7'h40) begin
                errors++;
                $display("FAIL reset_scan[%0d]: an=%h seg=%h, want an=%h seg=40", k, an, seg, exp_an);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        bit ok;
        store(BASE, 32'h1234_5678, 4'hF, 1'b1);
        checks++;
        if (disp_q !== 32'h1234_5678) begin
            errors++;
            $display("FAIL scan_disp_q: got %h want 12345678", disp_q);
        end
        for (int d = 0; d < 8; d++) begin
            wait_an(~(8'd1 << d), ok);
            checks++;
            if (!ok || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL scan_digit%0d: seen=%0d an=%h seg=%h want seg=%h", d, ok, an, seg, exp_seg[d]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [7:0] dig_an [4]  = '{8'hFE, 8'hFD, 8'hFB, 8'hEF};
        logic [6:0] dig_seg [4] = '{7'h03, 7'h08, 7'h40, 7'h21};
        bit ok;
        store(BASE, 32'h0, 4'hF, 1'b1);
        store(BASE, 32'hFFFF_FFAB, 4'b0001, 1'b1);
        checks++;
        if (disp_q !== 32'h0000_00AB) begin
            errors++;
            $display("FAIL strobe_byte0: got %h want 000000ab", disp_q);
        end
        store(BASE, 32'h11CD_2233, 4'b0100, 1'b1);
        checks++;
        if (disp_q !== 32'h00CD_00AB) begin
            errors++;
            $display("FAIL strobe_byte2: got %h want 00cd00ab", disp_q);
        end
        for (int i = 0; i < 4; i++) begin
            wait_an(dig_an[i], ok);
            checks++;
            if (!ok || seg !== dig_seg[i]) begin
                errors++;
                $display("FAIL strobe_digit an=%h: seen=%0d seg=%h want %h", dig_an[i], ok, seg, dig_seg[i]);
            end
        end
    endtask

    task automatic test_ctrl();
        bit seen_hi = 1'b0, found = 1'b0;
        logic [7:0] prev, held;
        store(BASE + 4, 32'h0000_0F01, 4'hF, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an !== 8'hFF) seen_hi = 1'b1;
            checks++;
            if (an[3:0] !== 4'hF || !(an[7:4] inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
                errors++;
                $display("FAIL ctrl_mask[%0d]: an=%h, want low bit only in 7..4", k, an);
            end
        end
        checks++;
        if (!seen_hi) begin
            errors++;
            $display("FAIL ctrl_mask_unmasked: an never went low for digits 4..7");
        end
        store(BASE + 4, 32'h0000_0001, 4'hF, 1'b1);
        prev = an;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (an === 8'hDF && prev !== 8'hDF) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ctrl_find_digit5: an=%h never entered df", an);
        end
        store(BASE + 4, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F) begin
                errors++;
                $display("FAIL ctrl_disabled[%0d]: an=%h seg=%h want ff/7f", k, an, seg);
            end
            @(negedge clk);
        end
        store(BASE + 4, 32'h1, 4'hF, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (an !== 8'hFF) break;
            @(negedge clk);
        end
        checks++;
        if (an !== 8'hDF) begin
            errors++;
            $display("FAIL ctrl_resume: an=%h want df", an);
        end
        store(BASE + 4, 32'h3, 4'hF, 1'b1);
        @(negedge clk);
        held = an;
        checks++;
        if (held === 8'hFF) begin
            errors++;
            $display("FAIL ctrl_hold_shown: an=%h want a selected digit", held);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (an !== held) begin
                errors++;
                $display("FAIL ctrl_hold[%0d]: an=%h want %h", k, an, held);
            end
        end
        store(BASE + 4, 32'h1, 4'hF, 1'b1);
    endtask

    task automatic test_ignore();
        bit ok;
        store(BASE + 8, 32'hDEAD_BEEF, 4'hF, 1'b1);
        checks++;
        if (disp_q !== 32'h00CD_00AB) begin
            errors++;
            $display("FAIL ignore_addr: got %h want 00cd00ab", disp_q);
        end
        store(BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
        checks++;
        if (disp_q !== 32'h00CD_00AB) begin
            errors++;
            $display("FAIL ignore_wen0: got %h want 00cd00ab", disp_q);
        end
        store(BASE + 4, 32'h0, 4'hF, 1'b0);
        wait_an(8'hFE, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_ctrl_kept: scanning stopped, an=%h", an);
        end
    endtask

    task automatic test_async_reset();
        bit ok, seen0 = 1'b0, seen1 = 1'b0, bad = 1'b0;
        wait_an(8'hDF, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL areset_reach5: an=%h never df", an);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || disp_q !== 32'h0) begin
            errors++;
            $display("FAIL areset_immediate: an=%h seg=%h disp_q=%h want ff/7f/0", an, seg, disp_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 8'hFE || seg !== 7'h40) begin
            errors++;
            $display("FAIL areset_idx0: an=%h seg=%h want fe/40", an, seg);
        end
        store(BASE, 32'h0000_0042, 4'hF, 1'b1);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if (an === 8'hFE && seg === 7'h24) seen0 = 1'b1;
            if (an === 8'hFD && seg === 7'h19) seen1 = 1'b1;
            if (!(an inside {8'hFF, 8'hFE, 8'hFD})) bad = 1'b1;
`else
            if (an === 8'hFD && seg === 7'h19) seen0 = 1'b1;
            if (an === 8'h7F && seg === 7'h40) seen1 = 1'b1;
`endif
        end
        checks++;
        if (!seen0 || !seen1 || bad) begin
            errors++;
            $display("FAIL lead_zero: seen_a=%0d seen_b=%0d stray_digit=%0d want 1/1/0", seen0, seen1, bad);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_scan();
        test_strobe();
        test_ctrl();
        test_ignore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
